// File: rtl/UART_MIKE_pkg.sv
// Shared UART types, sizes and frame helpers.
package UART_MIKE_pkg;

  localparam int unsigned UART_DATA_SIZE  = 8;
  localparam int unsigned UART_FRAME_SIZE = 4;
  localparam int unsigned UART_FRAME_MAX  = 12;

  typedef enum logic {IDLE, SEND} tx_ctrl_state_e;

  typedef logic [UART_FRAME_MAX-1:0] tx_frame_t;

  // Widths outside 5..8 fall back to a full byte.
  function automatic logic [3:0] eff_width(input logic [3:0] w);
    return (w >= 4'd5 && w <= 4'd8) ? w : 4'd8;
  endfunction

  // Start + data + optional parity + stop bits; w must already be effective.
  function automatic logic [3:0] frame_len(input logic [3:0] w, input logic pen,
                                           input logic stop2);
    return 4'd1 + w + {3'b000, pen} + (stop2 ? 4'd2 : 4'd1);
  endfunction

  // Everything above the data bits is forced to 1, so stop bits and unused
  // positions come for free; parity then overwrites position w+1.
  function automatic tx_frame_t build_frame(input logic [7:0] data, input logic [3:0] w,
                                            input logic pen, input logic podd);
    tx_frame_t  frame;
    logic [7:0] dmask;
    logic       par;
    dmask = 8'hFF >> (4'd8 - w);
    par   = (^(data & dmask)) ^ podd;
    frame = {3'b111, data, 1'b0} | (12'hFFF << (w + 4'd1));
    if (pen) frame[w + 4'd1] = par;
    return frame;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks in the last cycle of every divisor-length period.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] cnt_d, cnt_q;

  // Divisor clamp, end-of-period detect and counter next state.
  always_comb begin
    div_eff = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
    tick_o  = en_i && (cnt_q == div_eff - DIV_WIDTH'(1));
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte, latches the frame and sequences its bits.
module uart_tx_ctrl
  import UART_MIKE_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [DIV_WIDTH-1:0]       baud_div,
  input  logic [UART_FRAME_SIZE-1:0] uart_data_width,
  input  logic                       parity_en,
  input  logic                       parity_odd,
  input  logic                       stop2,
  input  logic                       tx_valid,
  input  logic [UART_DATA_SIZE-1:0]  tx_data,
  output logic                       tx_ready,
  output tx_frame_t                  tx_frame,
  output logic [UART_FRAME_SIZE-1:0] tx_index,
  output logic                       tx_shift,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
);

  tx_ctrl_state_e             state_d, state_q;
  tx_frame_t                  frame_d, frame_q;
  logic [UART_FRAME_SIZE-1:0] len_d, len_q;
  logic [UART_FRAME_SIZE-1:0] index_d, index_q;
  logic [DIV_WIDTH-1:0]       div_d, div_q;
  logic                       tx_d, tx_q;
  logic                       done_d, done_q;
  logic [3:0]                 w_eff;
  logic                       baud_clr;
  logic                       baud_tick;

  // The latched divisor is clamped inside the baud generator.
  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk    (clk),
    .n_rst  (n_rst),
    .div_i  (div_q),
    .clr_i  (baud_clr),
    .en_i   (state_q == SEND),
    .tick_o (baud_tick)
  );

  // Next-state logic: accept in IDLE, advance the bit index on each baud tick.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    len_d    = len_q;
    index_d  = index_q;
    div_d    = div_q;
    done_d   = 1'b0;
    baud_clr = 1'b0;
    w_eff    = eff_width(uart_data_width);
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d  = SEND;
          frame_d  = build_frame(tx_data, w_eff, parity_en, parity_odd);
          len_d    = frame_len(w_eff, parity_en, stop2);
          div_d    = baud_div;
          index_d  = '0;
          baud_clr = 1'b1;
        end
      end
      SEND: begin
        if (baud_tick) begin
          if (index_q == len_q - 4'd1) begin
            state_d = IDLE;
            index_d = '0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Line is registered from next state so the start bit shows right after accept.
    tx_d = (state_d == SEND) ? frame_d[index_d] : 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      frame_q <= '1;
      len_q   <= 4'd10;
      index_q <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      index_q <= index_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Output mapping.
  always_comb begin
    tx_ready = (state_q == IDLE);
    tx_busy  = (state_q == SEND);
    tx_shift = (state_q == SEND) && baud_tick;
    tx_frame = frame_q;
    tx_index = index_q;
    tx       = tx_q;
    tx_done  = done_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: vector table plus back-to-back and reset sequences.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] baud_div;
  logic [3:0]  uart_data_width;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [11:0] tx_frame;
  logic [3:0]  tx_index;
  logic        tx_shift;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;

  int tests = 0;
  int fails = 0;

  uart_tx_ctrl #(
    .DIV_WIDTH (16)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .baud_div        (baud_div),
    .uart_data_width (uart_data_width),
    .parity_en       (parity_en),
    .parity_odd      (parity_odd),
    .stop2           (stop2),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .tx_frame        (tx_frame),
    .tx_index        (tx_index),
    .tx_shift        (tx_shift),
    .tx              (tx),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div;
    logic [3:0]  w;
    logic        pen;
    logic        podd;
    logic        s2;
    logic [7:0]  data;
    logic [11:0] ef;   // expected frame, bit 0 sent first
    int          el;   // expected frame length
    int          de;   // expected cycles per bit
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " tx"}, 32'(tx), 32'd1);
    check({name, " ready"}, 32'(tx_ready), 32'd1);
    check({name, " busy"}, 32'(tx_busy), 32'd0);
    check({name, " index"}, 32'(tx_index), 32'd0);
    check({name, " frame"}, 32'(tx_frame), 32'hFFF);
    check({name, " shift"}, 32'(tx_shift), 32'd0);
    check({name, " done"}, 32'(tx_done), 32'd0);
  endtask

  // Called just after the accept edge; returns at the negedge of the tx_done cycle.
  task automatic check_frame(input string name, input logic [11:0] ef, input int el,
                             input int div);
    int c      = 0;
    int bad    = 0;
    int shifts = 0;
    bit got    = 0;
    while (c < 400 && !got) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        got = 1;
      end else begin
        if ((c / div) >= 12 || tx !== ef[c / div]) bad++;
        if (tx_busy !== 1'b1 || tx_ready !== 1'b0) bad++;
        if (tx_shift !== ((c % div) == div - 1)) bad++;
        if (tx_shift === 1'b1) shifts++;
        c++;
      end
    end
    check({name, " bit errors"}, 32'(bad), 32'd0);
    check({name, " frame cycles"}, 32'(c), 32'(el * div));
    check({name, " shift pulses"}, 32'(shifts), 32'(el));
    check({name, " latched frame"}, 32'(tx_frame), 32'(ef));
    check({name, " done tx/ready/busy"}, {29'd0, tx, tx_ready, tx_busy}, 32'b110);
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [3:0] w, input logic pen,
                         input logic podd, input logic s2, input logic [7:0] data);
    baud_div        = div;
    uart_data_width = w;
    parity_en       = pen;
    parity_odd      = podd;
    stop2           = s2;
    tx_data         = data;
  endtask

  initial begin
    //             div    w      pen   podd  s2    data   frame    L   cyc/bit
    vecs[0] = '{16'd4, 4'd8,  1'b0, 1'b0, 1'b0, 8'hA5, 12'hF4A, 10, 4};
    vecs[1] = '{16'd2, 4'd7,  1'b1, 1'b0, 1'b0, 8'h55, 12'hEAA, 10, 2};
    vecs[2] = '{16'd2, 4'd7,  1'b1, 1'b1, 1'b0, 8'h55, 12'hFAA, 10, 2};
    vecs[3] = '{16'd0, 4'd12, 1'b0, 1'b0, 1'b0, 8'h3C, 12'hE78, 10, 2};
    vecs[4] = '{16'd3, 4'd5,  1'b0, 1'b0, 1'b1, 8'h13, 12'hFE6, 8,  3};
    vecs[5] = '{16'd2, 4'd6,  1'b1, 1'b0, 1'b1, 8'h2D, 12'hF5A, 10, 2};
    vecs[6] = '{16'd1, 4'd5,  1'b0, 1'b0, 1'b0, 8'h1F, 12'hFFE, 7,  2};
    vecs[7] = '{16'd3, 4'd8,  1'b1, 1'b0, 1'b1, 8'hFF, 12'hDFE, 12, 3};

    n_rst    = 1'b0;
    tx_valid = 1'b0;
    set_cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    n_rst = 1'b1;

    // Valid is raised while ready is high; config is scrambled right after accept.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_cfg(vecs[i].div, vecs[i].w, vecs[i].pen, vecs[i].podd, vecs[i].s2, vecs[i].data);
      tx_valid = 1'b1;
      check($sformatf("vec%0d ready", i), 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      set_cfg(16'd7, 4'd6, ~vecs[i].pen, ~vecs[i].podd, ~vecs[i].s2, ~vecs[i].data);
      check_frame($sformatf("vec%0d", i), vecs[i].ef, vecs[i].el, vecs[i].de);
    end

    // Back-to-back with tx_valid held: second start bit follows the stop bits directly.
    @(negedge clk);
    set_cfg(16'd2, 4'd5, 1'b0, 1'b0, 1'b1, 8'h13);
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    check_frame("b2b first", 12'hFE6, 8, 2);
    tx_data = 8'h0C;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_frame("b2b second", 12'hFD8, 8, 2);

    // Reset during data bit 3 (cycles 16..19 at 4 cycles per bit).
    @(negedge clk);
    set_cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0, 8'h00);
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("midframe tx before reset", {30'd0, tx, tx_busy}, 32'b01);
    n_rst = 1'b0;
    #1;
    check_reset_vals("midframe reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_frame("after reset", 12'hE00, 10, 4);

    // Idle valid-low cycles leave the controller idle.
    repeat (3) @(negedge clk);
    check("idle stays idle", {30'd0, tx_busy, tx}, 32'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
